// File: rtl/cic_pkg.sv
// Shared CIC constants: default geometry for the interpolator/decimator pair
// and helpers giving the saturation bounds of a signed output word.
package cic_pkg;

    localparam int CIC_WIDTH   = 24;
    localparam int CIC_INTERP  = 64;
    localparam int CIC_IN_BITS = 16;
    localparam int CIC_BITS    = 8;
    localparam int CIC_SHIFT   = 14;

    // Largest value representable in a signed word of the given width
    function automatic int sat_hi(input int bits);
        return (1 <<< (bits - 1)) - 1;
    endfunction

    // Smallest value representable in a signed word of the given width
    function automatic int sat_lo(input int bits);
        return -(1 <<< (bits - 1));
    endfunction

endpackage

// File: rtl/cic_comb2.sv
// Two-stage low-rate comb (differential delay 1). The difference outputs are
// combinational on the current sample; the delay registers advance only when
// i_en marks a consumed low-rate sample.
module cic_comb2 import cic_pkg::*; #(
    parameter int WIDTH = CIC_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_s,
    output logic signed [WIDTH-1:0] o_c2
);

    logic signed [WIDTH-1:0] r_s_del;
    logic signed [WIDTH-1:0] r_c1_del;
    logic signed [WIDTH-1:0] w_c1;

    assign w_c1 = i_s - r_s_del;
    assign o_c2 = w_c1 - r_c1_del;

    // Advance both comb delay lines once per consumed low-rate sample
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s_del  <= '0;
            r_c1_del <= '0;
        end else if (i_en) begin
            r_s_del  <= i_s;
            r_c1_del <= w_c1;
        end
    end

endmodule

// File: rtl/cic_interp_lite.sv
// Two-stage CIC interpolator: one-word input holding register, low-rate comb,
// zero stuffing by the phase counter, two high-rate integrators and a
// shifted, saturated output register. in_tick paces the high-rate side.
module cic_interp_lite import cic_pkg::*; #(
    parameter int WIDTH   = CIC_WIDTH,
    parameter int INTERP  = CIC_INTERP,
    parameter int IN_BITS = CIC_IN_BITS,
    parameter int BITS    = CIC_BITS,
    parameter int SHIFT   = CIC_SHIFT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    input  logic signed [IN_BITS-1:0] x_in,
    output logic                      in_ready,
    input  logic                      in_tick,
    output logic signed [BITS-1:0]    x_out,
    output logic                      out_tick,
    output logic                      underrun
);

    localparam logic [7:0]              PHASE_LAST = 8'(INTERP - 1);
    localparam logic signed [WIDTH-1:0] OUT_MAX    = WIDTH'(sat_hi(BITS));
    localparam logic signed [WIDTH-1:0] OUT_MIN    = WIDTH'(sat_lo(BITS));

    logic [7:0]                r_phase;
    logic                      r_hold_full;
    logic signed [IN_BITS-1:0] r_hold_data;
    logic signed [WIDTH-1:0]   r_integ1;
    logic signed [WIDTH-1:0]   r_integ2;

    logic                      w_xfer;
    logic                      w_phase0;
    logic                      w_consume;
    logic signed [WIDTH-1:0]   w_s;
    logic signed [WIDTH-1:0]   w_c2;
    logic signed [WIDTH-1:0]   w_stuffed;

    // Scale the second integrator down to the output word and clamp it
    function automatic logic signed [BITS-1:0] sat_out(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] sh;
        sh = v >>> SHIFT;
        if (sh > OUT_MAX)
            return OUT_MAX[BITS-1:0];
        else if (sh < OUT_MIN)
            return OUT_MIN[BITS-1:0];
        else
            return sh[BITS-1:0];
    endfunction

    assign in_ready  = ~r_hold_full;
    assign w_xfer    = in_valid && in_ready;
    assign w_phase0  = (r_phase == 8'd0);
    assign w_consume = in_tick && w_phase0;
    // An empty holding register feeds zero into the comb; a word arriving in
    // the same cycle is not bypassed and waits for the next phase 0.
    assign w_s       = r_hold_full ? WIDTH'(r_hold_data) : '0;
    assign w_stuffed = w_phase0 ? w_c2 : '0;

    cic_comb2 #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_clk (CLK),
        .i_rst (RST),
        .i_en  (w_consume),
        .i_s   (w_s),
        .o_c2  (w_c2)
    );

    // Phase counter: one step per high-rate tick, wrapping at INTERP-1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_phase <= '0;
        else if (in_tick)
            r_phase <= (r_phase == PHASE_LAST) ? 8'd0 : r_phase + 8'd1;
    end

    // Holding register: filled by the handshake, emptied by a phase-0 consume
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            if (w_consume && r_hold_full)
                r_hold_full <= 1'b0;
            if (w_xfer) begin
                r_hold_data <= x_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    // Sticky underrun: a consume found the holding register empty
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            underrun <= 1'b0;
        else if (w_consume && !r_hold_full)
            underrun <= 1'b1;
    end

    // High-rate integrators and output register, all using pre-update values
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_integ1 <= '0;
            r_integ2 <= '0;
            x_out    <= '0;
            out_tick <= 1'b0;
        end else begin
            out_tick <= in_tick;
            if (in_tick) begin
                r_integ1 <= r_integ1 + w_stuffed;
                r_integ2 <= r_integ2 + r_integ1;
                x_out    <= sat_out(r_integ2);
            end
        end
    end

endmodule

// File: tb/tb_cic_interp_lite.sv
module tb_cic_interp_lite;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic               in_ready;
    logic               in_tick;
    logic signed [7:0]  x_out;
    logic               out_tick;
    logic               underrun;

    cic_interp_lite dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .x_in     (x_in),
        .in_ready (in_ready),
        .in_tick  (in_tick),
        .x_out    (x_out),
        .out_tick (out_tick),
        .underrun (underrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state (defaults: INTERP 64, SHIFT 14, WIDTH 24)
    int                 m_phase;
    logic               m_full;
    int                 m_data;
    logic               m_under;
    logic signed [23:0] m_sdel;
    logic signed [23:0] m_c1del;
    logic signed [23:0] m_i1;
    logic signed [23:0] m_i2;

    int   exp_q[$];
    logic prev_tick;
    int   out_idx;
    int   hist[512];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_model(input logic signed [23:0] v);
        int q;
        q = int'(v >>> 14);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_full = 1'b0; m_data = 0; m_under = 1'b0;
        m_sdel = '0; m_c1del = '0; m_i1 = '0; m_i2 = '0;
        exp_q.delete();
        prev_tick = 1'b0;
        out_idx = 0;
    endtask

    task automatic model_step(input logic v, input int x, input logic t);
        logic               xfer;
        logic signed [23:0] s;
        logic signed [23:0] c1;
        logic signed [23:0] st;
        xfer = v && !m_full;
        st = '0;
        if (t) begin
            if (m_phase == 0) begin
                if (m_full) begin
                    s = 24'(m_data);
                    m_full = 1'b0;
                end else begin
                    s = '0;
                    m_under = 1'b1;
                end
                c1 = s - m_sdel;
                st = c1 - m_c1del;
                m_sdel = s;
                m_c1del = c1;
            end
            exp_q.push_back(sat_model(m_i2));
            m_i2 = m_i2 + m_i1;
            m_i1 = m_i1 + st;
            m_phase = (m_phase == 63) ? 0 : m_phase + 1;
        end
        if (xfer) begin
            m_data = x;
            m_full = 1'b1;
        end
    endtask

    // Compare DUT state left by the previous rising edge (called at negedge)
    task automatic observe();
        int e;
        check("out_tick", 32'(out_tick), 32'(prev_tick));
        if (prev_tick) begin
            e = exp_q.pop_front();
            check("x_out", 32'(x_out), e);
            hist[out_idx] = int'(x_out);
            out_idx++;
        end
        check("underrun", 32'(underrun), 32'(m_under));
        check("in_ready", 32'(in_ready), 32'(!m_full));
    endtask

    task automatic drive(input logic v, input int x, input logic t);
        @(negedge CLK);
        observe();
        in_valid = v;
        x_in = 16'(x);
        in_tick = t;
        model_step(v, x, t);
        prev_tick = t;
    endtask

    // ticks high-rate outputs with in_tick on every fourth cycle
    task automatic run(input logic v, input int x, input int ticks);
        for (int k = 0; k < ticks; k++) begin
            for (int c = 0; c < 3; c++) drive(v, x, 1'b0);
            drive(v, x, 1'b1);
        end
        drive(1'b0, 0, 1'b0);
    endtask

    // Assert RST between clock edges and check the asynchronous clear
    task automatic async_reset(input string tag);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check({tag, "_x_out"},    32'(x_out),    0);
        check({tag, "_out_tick"}, 32'(out_tick), 0);
        check({tag, "_underrun"}, 32'(underrun), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        in_valid = 1'b0;
        in_tick = 1'b0;
        x_in = '0;
        model_clear();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        in_valid = 1'b1;
        x_in = 16'sd123;
        in_tick = 1'b1;
        model_clear();
        repeat (3) @(negedge CLK);
        check("rst_x_out",    32'(x_out),    0);
        check("rst_out_tick", 32'(out_tick), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        in_tick = 1'b0;
        x_in = '0;
        RST = 1'b0;

        // Constant 16384: ramp 0,0,1,2,... to 64
        run(1'b1, 16384, 100);
        check("ramp_idx0",  hist[0],  0);
        check("ramp_idx1",  hist[1],  0);
        check("ramp_idx2",  hist[2],  1);
        check("ramp_idx3",  hist[3],  2);
        check("ramp_idx64", hist[64], 63);
        check("ramp_idx65", hist[65], 64);
        check("ramp_idx99", hist[99], 64);
        check("ramp_under", 32'(underrun), 0);

        // Reset mid-ramp at phase 30, then the ramp must restart identically
        async_reset("ar0");
        run(1'b1, 16384, 30);
        async_reset("ar30");
        run(1'b1, 16384, 70);
        check("rr_idx2",  hist[2],  1);
        check("rr_idx30", hist[30], 29);
        check("rr_idx65", hist[65], 64);
        check("rr_idx69", hist[69], 64);

        // Single impulse of 16384 then zeros: triangle peaking at 64
        async_reset("ar_tri");
        run(1'b1, 16384, 1);
        run(1'b1, 0, 139);
        check("tri_idx65",  hist[65],  64);
        check("tri_idx97",  hist[97],  32);
        check("tri_idx129", hist[129], 0);
        check("tri_idx139", hist[139], 0);

        // Full-scale negative and positive constants
        async_reset("ar_neg");
        run(1'b1, -32768, 80);
        check("neg_idx66", hist[66], -128);
        check("neg_idx79", hist[79], -128);
        async_reset("ar_pos");
        run(1'b1, 32767, 80);
        check("pos_idx66", hist[66], 127);
        check("pos_idx79", hist[79], 127);

        // No data at the consume tick: sticky underrun, zero stuffed
        async_reset("ar_ur");
        run(1'b0, 0, 2);
        check("ur_flag",  32'(underrun), 1);
        check("ur_ready", 32'(in_ready), 1);
        run(1'b1, 16384, 70);
        check("ur_sticky", 32'(underrun), 1);
        check("ur_idx1",   hist[1],  0);
        check("ur_idx64",  hist[64], 0);
        check("ur_idx66",  hist[66], 1);

        // Word offered on the same cycle as a consume with empty hold
        async_reset("ar_same");
        for (int c = 0; c < 3; c++) drive(1'b0, 0, 1'b0);
        drive(1'b1, 16384, 1'b1);
        drive(1'b0, 0, 1'b0);
        check("same_under", 32'(underrun), 1);
        check("same_held",  32'(in_ready), 0);
        // Later offers are ignored while the word waits for phase 0
        for (int c = 0; c < 2; c++) drive(1'b0, 0, 1'b0);
        drive(1'b1, -9999, 1'b1);
        run(1'b1, -9999, 66);
        check("same_idx64", hist[64], 0);
        check("same_idx65", hist[65], 0);
        check("same_idx66", hist[66], 1);
        check("same_idx67", hist[67], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
